// File: rtl/muldiv_pkg.sv
// Shared constants for the mult/div sequencer: state encoding, HI/LO mux
// select values and exception-kind encoding.
package muldiv_pkg;

  localparam int unsigned STATE_W = 3;

  // FSM state encoding
  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_MULT_RUN = 3'd1;
  localparam logic [STATE_W-1:0] ST_DIV_RUN  = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOAD     = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE     = 3'd4;
  localparam logic [STATE_W-1:0] ST_ERR      = 3'd5;

  // HI/LO source select
  localparam logic SEL_DIV  = 1'b0;
  localparam logic SEL_MULT = 1'b1;

  // Exception kind latched on entry to ERR
  localparam logic EXC_DZ = 1'b0;
  localparam logic EXC_TO = 1'b1;

endpackage

// File: rtl/muldiv_run_counter.sv
// RUN-state cycle counter.
// Ports: clk, reset (sync, active-high), clear (zero the count),
//        enable (increment), first (count==0), expire (count==MAX_CYCLES-1).
module muldiv_run_counter
  import muldiv_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic first,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Count register; clear wins over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign first  = (count == '0);
  assign expire = (count == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the iterative mult/div units: issues one start pulse, waits for
// the unit's stop flag, loads HI/LO, then reports done or an exception.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start_mult/div    : one-cycle requests from control (mult wins if both)
//   mult_stop/div_stop: unit finished; div_zero: zero divisor seen
//   hilo_read_req     : mfhi/mflo pending
//   mult_control/div_control : unit start pulses
//   sel_mux_hi/lo     : HI/LO source (0=div, 1=mult), follows the op register
//   HiLo_load         : HI/LO write enable
//   busy, done, div_zero_exc, timeout_exc : status, decoded from state
//   stall             : combinational hilo_read_req && busy
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  input  logic mult_stop,
  input  logic div_stop,
  input  logic div_zero,
  input  logic hilo_read_req,
  output logic mult_control,
  output logic div_control,
  output logic sel_mux_hi,
  output logic sel_mux_lo,
  output logic HiLo_load,
  output logic busy,
  output logic done,
  output logic div_zero_exc,
  output logic timeout_exc,
  output logic stall
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic               op;
  logic               op_next;
  logic               exc_kind;
  logic               exc_next;
  logic               in_run;
  logic               cnt_first;
  logic               cnt_expire;

  assign in_run = (state == ST_MULT_RUN) || (state == ST_DIV_RUN);

  // Count is held at zero outside RUN, so every RUN entry starts at 0
  muldiv_run_counter #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_run_counter (
    .clk   (clk),
    .reset (reset),
    .clear (!in_run),
    .enable(in_run),
    .first (cnt_first),
    .expire(cnt_expire)
  );

  // State, op and exception-kind registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op       <= SEL_DIV;
      exc_kind <= EXC_DZ;
    end else begin
      state    <= state_next;
      op       <= op_next;
      exc_kind <= exc_next;
    end
  end

  // Next-state logic; starts outside IDLE are simply not looked at
  always_comb begin
    state_next = state;
    op_next    = op;
    exc_next   = exc_kind;
    case (state)
      ST_IDLE: begin
        if (start_mult) begin
          op_next    = SEL_MULT;
          state_next = ST_MULT_RUN;
        end else if (start_div) begin
          op_next    = SEL_DIV;
          state_next = ST_DIV_RUN;
        end
      end
      ST_MULT_RUN: begin
        if (mult_stop) begin
          state_next = ST_LOAD;
        end else if (cnt_expire) begin
          exc_next   = EXC_TO;
          state_next = ST_ERR;
        end
      end
      ST_DIV_RUN: begin
        // Zero divisor outranks a simultaneous stop
        if (div_zero) begin
          exc_next   = EXC_DZ;
          state_next = ST_ERR;
        end else if (div_stop) begin
          state_next = ST_LOAD;
        end else if (cnt_expire) begin
          exc_next   = EXC_TO;
          state_next = ST_ERR;
        end
      end
      ST_LOAD: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode from registered state
  assign mult_control = (state == ST_MULT_RUN) && cnt_first;
  assign div_control  = (state == ST_DIV_RUN) && cnt_first;
  assign sel_mux_hi   = op;
  assign sel_mux_lo   = op;
  assign HiLo_load    = (state == ST_LOAD);
  assign busy         = in_run || (state == ST_LOAD);
  assign done         = (state == ST_DONE);
  assign div_zero_exc = (state == ST_ERR) && (exc_kind == EXC_DZ);
  assign timeout_exc  = (state == ST_ERR) && (exc_kind == EXC_TO);
  assign stall        = hilo_read_req && busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a table of single-operation vectors
// with hand-computed event cycles, plus hand-written reset and timeout runs.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (MAX_CYCLES=64)
  logic reset, start_mult, start_div, mult_stop, div_stop, div_zero, hilo_read_req;
  logic mult_control, div_control, sel_mux_hi, sel_mux_lo, HiLo_load;
  logic busy, done, div_zero_exc, timeout_exc, stall;

  // Short-timeout instance (MAX_CYCLES=4)
  logic t_start_mult, t_start_div, t_mult_stop, t_div_stop, t_div_zero, t_hilo_read_req;
  logic t_mult_control, t_div_control, t_sel_mux_hi, t_sel_mux_lo, t_HiLo_load;
  logic t_busy, t_done, t_div_zero_exc, t_timeout_exc, t_stall;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset),
    .start_mult(start_mult), .start_div(start_div),
    .mult_stop(mult_stop), .div_stop(div_stop), .div_zero(div_zero),
    .hilo_read_req(hilo_read_req),
    .mult_control(mult_control), .div_control(div_control),
    .sel_mux_hi(sel_mux_hi), .sel_mux_lo(sel_mux_lo), .HiLo_load(HiLo_load),
    .busy(busy), .done(done), .div_zero_exc(div_zero_exc),
    .timeout_exc(timeout_exc), .stall(stall)
  );

  muldiv_sequencer #(.MAX_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset),
    .start_mult(t_start_mult), .start_div(t_start_div),
    .mult_stop(t_mult_stop), .div_stop(t_div_stop), .div_zero(t_div_zero),
    .hilo_read_req(t_hilo_read_req),
    .mult_control(t_mult_control), .div_control(t_div_control),
    .sel_mux_hi(t_sel_mux_hi), .sel_mux_lo(t_sel_mux_lo), .HiLo_load(t_HiLo_load),
    .busy(t_busy), .done(t_done), .div_zero_exc(t_div_zero_exc),
    .timeout_exc(t_timeout_exc), .stall(t_stall)
  );

  int total = 0;
  int bad   = 0;
  logic prev_sel = 1'b0;

  // One operation: input timing plus the cycle of every expected event
  // (cycle 0 = start request cycle, -1 = never).
  typedef struct {
    logic sm;        // start_mult in cycle 0
    logic sd;        // start_div in cycle 0
    logic rd;        // hilo_read_req held
    logic stop_mult; // 1: raise mult_stop, 0: raise div_stop
    int   stop_c;    // cycle of stop flag
    int   dzin_c;    // cycle of div_zero
    int   junk_c;    // cycle of start_div+div_stop+div_zero noise
    int   mc;        // expected mult_control cycle
    int   dc;        // expected div_control cycle
    logic sel;       // expected select after start
    int   load;      // expected HiLo_load cycle
    int   done_c;    // expected done cycle
    int   dz_c;      // expected div_zero_exc cycle
    int   to_c;      // expected timeout_exc cycle
    int   busy_last; // busy over cycles 1..busy_last
    int   len;       // last cycle checked
  } vec_t;

  vec_t vecs[7];

  // {mult_control, div_control, sel_hi, sel_lo, HiLo_load, busy, done, dz, to, stall}
  function automatic logic [9:0] pack();
    return {mult_control, div_control, sel_mux_hi, sel_mux_lo, HiLo_load,
            busy, done, div_zero_exc, timeout_exc, stall};
  endfunction

  function automatic logic [9:0] pack4();
    return {t_mult_control, t_div_control, t_sel_mux_hi, t_sel_mux_lo, t_HiLo_load,
            t_busy, t_done, t_div_zero_exc, t_timeout_exc, t_stall};
  endfunction

  function automatic logic [9:0] exp_vec(input vec_t v, input int c, input logic psel);
    logic b;
    logic s;
    b = (c >= 1) && (c <= v.busy_last);
    s = (c == 0) ? psel : v.sel;
    return {c == v.mc, c == v.dc, s, s, c == v.load, b, c == v.done_c,
            c == v.dz_c, c == v.to_c, v.rd && b};
  endfunction

  task automatic check(input string name, input int c, input logic [9:0] act,
                       input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b want %b", name, c, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_mult = 0; start_div = 0; mult_stop = 0; div_stop = 0;
    div_zero = 0; hilo_read_req = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", idx);
    for (int c = 0; c <= v.len; c++) begin
      check(nm, c, pack(), exp_vec(v, c, prev_sel));
      start_mult    = (c == 0) && v.sm;
      start_div     = ((c == 0) && v.sd) || (c == v.junk_c);
      mult_stop     = v.stop_mult && (c == v.stop_c);
      div_stop      = (!v.stop_mult && (c == v.stop_c)) || (c == v.junk_c);
      div_zero      = (c == v.dzin_c) || (c == v.junk_c);
      hilo_read_req = v.rd;
      step();
    end
    clear_inputs();
    prev_sel = v.sel;
  endtask

  initial begin
    logic [9:0] e;
    logic [4:0] e5;
    logic b;
    logic s;

    //        sm    sd    rd    smul  stop dzin junk mc  dc  sel   load done dz  to  busy len
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 33,  -1,  -1,  1, -1, 1'b1, 34,  35, -1, -1, 34, 36};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0,  3,  -1,  -1, -1,  1, 1'b0,  4,   5, -1, -1,  4,  6};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0,  2,   2,  -1, -1,  1, 1'b0, -1,  -1,  3, -1,  2,  4};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1,  4,  -1,   2,  1, -1, 1'b1,  5,   6, -1, -1,  5,  7};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1,  1,  -1,  -1,  1, -1, 1'b1,  2,   3, -1, -1,  2,  4};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0,  6,  -1,  -1, -1,  1, 1'b0,  7,   8, -1, -1,  7,  9};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, -1,   1,  -1, -1,  1, 1'b0, -1,  -1,  2, -1,  1,  3};

    clear_inputs();
    t_start_mult = 0; t_start_div = 0; t_mult_stop = 0; t_div_stop = 0;
    t_div_zero = 0; t_hilo_read_req = 0;
    reset = 1;
    step();
    step();
    check("reset_main", 0, pack(), 10'b0);
    check("reset_short", 0, pack4(), 10'b0);
    reset = 0;
    step();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset during RUN cycle 10 of a mult with hilo_read_req held
    start_mult = 1;
    hilo_read_req = 1;
    step();
    start_mult = 0;
    for (int c = 1; c <= 11; c++) begin
      e5 = {c == 1, 1'b0, 1'b1, 1'b1, 1'b0};
      total++;
      if ({mult_control, HiLo_load, busy, stall, done} !== e5) begin
        bad++;
        $display("FAIL pre_reset cycle %0d: got %b want %b", c,
                 {mult_control, HiLo_load, busy, stall, done}, e5);
      end
      if (c == 11) reset = 1;
      step();
    end
    check("after_reset", 12, pack(), 10'b0);
    reset = 0;
    step();
    check("idle_after_reset", 13, pack(), 10'b0);
    step();
    check("idle_after_reset", 14, pack(), 10'b0);
    clear_inputs();

    // Mult timeout with MAX_CYCLES=4, read request held
    for (int c = 0; c <= 6; c++) begin
      b = (c >= 1) && (c <= 4);
      s = (c >= 1);
      e = {c == 1, 1'b0, s, s, 1'b0, b, 1'b0, 1'b0, c == 5, b};
      check("timeout_mult", c, pack4(), e);
      t_start_mult    = (c == 0);
      t_hilo_read_req = 1;
      step();
    end
    t_hilo_read_req = 0;

    // Div stop in the last RUN cycle beats the timeout
    for (int c = 0; c <= 7; c++) begin
      b = (c >= 1) && (c <= 5);
      s = (c == 0);
      e = {1'b0, c == 1, s, s, c == 5, b, c == 6, 1'b0, 1'b0, 1'b0};
      check("stop_vs_timeout", c, pack4(), e);
      t_start_div = (c == 0);
      t_div_stop  = (c == 4);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
